jtsbaskt_pcm_fetch: RTL and testbench



---
 rtl/jtsbaskt_pcm_pkg.sv | 26 ++
 rtl/jtsbaskt_pcm_fetch_if.sv | 29 ++
 rtl/jtsbaskt_pcm_entry.sv | 53 +++++
 rtl/jtsbaskt_pcm_fetch.sv | 156 +++++++++++++++
 tb/tb_jtsbaskt_pcm_fetch.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/jtsbaskt_pcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtsbaskt_pcm_pkg
//  Purpose  : Shared types and constants for the VLM5030 PCM fetch cache.
//  Revision : 1.0  initial release
// ============================================================================
package jtsbaskt_pcm_pkg;

    typedef enum logic [1:0] {
        PCM_IDLE   = 2'd0,
        PCM_DEMAND = 2'd1,
        PCM_PREF   = 2'd2
    } pcm_state_e;

    // Even byte addresses map to word bits [7:0] (little-endian ROM image)
    localparam bit PCM_LOW_BYTE_EVEN = 1'b1;

    // Pick the byte of a 16-bit word addressed by the byte-address LSB
    function automatic logic [7:0] pcm_byte_sel(input logic [15:0] word, input logic odd);
        logic sel_hi;
        sel_hi = PCM_LOW_BYTE_EVEN ? odd : ~odd;
        return sel_hi ? word[15:8] : word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtsbaskt_pcm_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtsbaskt_pcm_fetch_if
//  Purpose  : PCM byte port (sound board side) and SDRAM word port bundle.
//             master = the fetch cache, slave = sound board + SDRAM slot.
//  Revision : 1.0  initial release
// ============================================================================
interface jtsbaskt_pcm_fetch_if #(
    parameter int AW = 16
);
    logic [AW-1:0] pcm_addr;
    logic [7:0]    pcm_data;
    logic          pcm_ok;
    logic [AW-2:0] sdram_addr;
    logic          sdram_cs;
    logic [15:0]   sdram_data;
    logic          sdram_ok;

    modport master (
        input  pcm_addr, sdram_data, sdram_ok,
        output pcm_data, pcm_ok, sdram_addr, sdram_cs
    );

    modport slave (
        output pcm_addr, sdram_data, sdram_ok,
        input  pcm_data, pcm_ok, sdram_addr, sdram_cs
    );
endinterface
`default_nettype wire

// File: rtl/jtsbaskt_pcm_entry.sv
`default_nettype none
// ============================================================================
//  Module   : jtsbaskt_pcm_entry
//  Purpose  : One cache entry (valid/tag/word) with hit detect and byte select.
//  Revision : 1.0  initial release
// ============================================================================
module jtsbaskt_pcm_entry
    import jtsbaskt_pcm_pkg::*;
#(
    parameter int AW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clr_i,
    input  wire logic          fill_i,
    input  wire logic [AW-2:0] fill_tag_i,
    input  wire logic [15:0]   fill_word_i,
    input  wire logic [AW-1:0] addr_i,
    output logic               valid_o,
    output logic               hit_o,
    output logic [7:0]         byte_o,
    output logic [AW-2:0]      tag_o
);

    logic          valid_q;
    logic [AW-2:0] tag_q;
    logic [15:0]   word_q;

    // Entry storage: clear drops only the valid bit, fill loads tag and word
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else begin
            if (clr_i)
                valid_q <= 1'b0;
            else if (fill_i)
                valid_q <= 1'b1;
            if (fill_i) begin
                tag_q  <= fill_tag_i;
                word_q <= fill_word_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign hit_o   = valid_q && (tag_q == addr_i[AW-1:1]);
    assign byte_o  = pcm_byte_sel(word_q, addr_i[0]);
    assign tag_o   = tag_q;

endmodule
`default_nettype wire

// File: rtl/jtsbaskt_pcm_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : jtsbaskt_pcm_fetch
//  Purpose  : Two-entry word cache between the VLM5030 sample-ROM byte port
//             and a 16-bit SDRAM ROM slot. pcm_ok is a combinational hit.
//             Define JTSBASKT_PCM_PREFETCH_EN to compile in sequential
//             next-word prefetch (PREF state).
//  Revision : 1.0  initial release
// ============================================================================
module jtsbaskt_pcm_fetch
    import jtsbaskt_pcm_pkg::*;
#(
    parameter int AW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          dwnld_busy,
    jtsbaskt_pcm_fetch_if.master bus
);

    localparam logic [1:0] S_IDLE   = PCM_IDLE;
    localparam logic [1:0] S_DEMAND = PCM_DEMAND;
`ifdef JTSBASKT_PCM_PREFETCH_EN
    localparam logic [1:0] S_PREF   = PCM_PREF;
`endif

    logic [1:0]    state_q, state_d;
    logic          cs_q, cs_d;
    logic [AW-2:0] addr_q, addr_d;
    logic          victim_q, victim_d;
    logic          rp_q, rp_d;

    logic          w_valid0, w_valid1, w_hit0, w_hit1, w_hit;
    logic [7:0]    w_byte0, w_byte1;
    logic [AW-2:0] w_tag0, w_tag1;
    logic          w_fill;

    // A fill only lands for an acknowledged outstanding request outside download
    assign w_fill = cs_q && bus.sdram_ok && !dwnld_busy;

    jtsbaskt_pcm_entry #(.AW(AW)) u_e0 (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (dwnld_busy),
        .fill_i      (w_fill && !victim_q),
        .fill_tag_i  (addr_q),
        .fill_word_i (bus.sdram_data),
        .addr_i      (bus.pcm_addr),
        .valid_o     (w_valid0),
        .hit_o       (w_hit0),
        .byte_o      (w_byte0),
        .tag_o       (w_tag0)
    );

    jtsbaskt_pcm_entry #(.AW(AW)) u_e1 (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (dwnld_busy),
        .fill_i      (w_fill && victim_q),
        .fill_tag_i  (addr_q),
        .fill_word_i (bus.sdram_data),
        .addr_i      (bus.pcm_addr),
        .valid_o     (w_valid1),
        .hit_o       (w_hit1),
        .byte_o      (w_byte1),
        .tag_o       (w_tag1)
    );

    assign w_hit         = w_hit0 || w_hit1;
    assign bus.pcm_ok    = w_hit;
    assign bus.pcm_data  = (w_hit1 && !w_hit0) ? w_byte1 : w_byte0;
    assign bus.sdram_addr = addr_q;
    assign bus.sdram_cs  = cs_q;

`ifdef JTSBASKT_PCM_PREFETCH_EN
    logic [AW-2:0] w_hit_tag, w_next_tag;
    logic          w_next_held;

    // Next sequential word after the one being read, wrapping at the top
    assign w_hit_tag   = w_hit0 ? w_tag0 : w_tag1;
    assign w_next_tag  = w_hit_tag + {{(AW-2){1'b0}}, 1'b1};
    assign w_next_held = (w_valid0 && (w_tag0 == w_next_tag)) ||
                         (w_valid1 && (w_tag1 == w_next_tag));
`else
    logic w_unused_pref;
    assign w_unused_pref = ^{w_valid0, w_valid1, w_tag0, w_tag1};
`endif

    // Request sequencer: demand on miss, optional prefetch on hit, one request at a time
    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        addr_d   = addr_q;
        victim_d = victim_q;
        rp_d     = rp_q;
        case (state_q)
            S_IDLE: begin
                if (!w_hit) begin
                    state_d  = S_DEMAND;
                    cs_d     = 1'b1;
                    addr_d   = bus.pcm_addr[AW-1:1];
                    victim_d = rp_q;
                end
`ifdef JTSBASKT_PCM_PREFETCH_EN
                else if (!w_next_held) begin
                    state_d  = S_PREF;
                    cs_d     = 1'b1;
                    addr_d   = w_next_tag;
                    victim_d = w_hit0;
                end
`endif
            end
`ifdef JTSBASKT_PCM_PREFETCH_EN
            S_DEMAND, S_PREF: begin
`else
            S_DEMAND: begin
`endif
                if (bus.sdram_ok) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b0;
                    if (state_q == S_DEMAND)
                        rp_d = ~rp_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b0;
            end
        endcase
        // Download owns the SDRAM slot: abandon the request, ignore any ack
        if (dwnld_busy) begin
            state_d = S_IDLE;
            cs_d    = 1'b0;
            rp_d    = rp_q;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cs_q     <= 1'b0;
            addr_q   <= '0;
            victim_q <= 1'b0;
            rp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            rp_q     <= rp_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtsbaskt_pcm_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtsbaskt_pcm_fetch
//  Purpose  : Directed self-checking bench for the PCM fetch cache.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtsbaskt_pcm_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dwnld_busy = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   req_cnt = 0;
    int   req_base = 0;
    logic cs_prev = 1'b0;

    jtsbaskt_pcm_fetch_if #(.AW(16)) bus ();

    jtsbaskt_pcm_fetch #(.AW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .dwnld_busy (dwnld_busy),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // Count rising edges of sdram_cs (one per request)
    always @(negedge clk) begin
        if (bus.sdram_cs && !cs_prev) req_cnt++;
        cs_prev = bus.sdram_cs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cs(input string tag);
        int n;
        n = 0;
        while (bus.sdram_cs !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.sdram_cs}, 32'd1);
    endtask

    // Wait for a request, check its address, ack after lat cycles
    task automatic serve(input logic [14:0] exp_addr, input logic [15:0] d, input int lat);
        wait_cs("req_cs");
        chk("req_addr", {17'd0, bus.sdram_addr}, {17'd0, exp_addr});
        repeat (lat) step();
        chk("cs_held", {31'd0, bus.sdram_cs}, 32'd1);
        chk("addr_stable", {17'd0, bus.sdram_addr}, {17'd0, exp_addr});
        bus.sdram_data = d;
        bus.sdram_ok   = 1'b1;
        step();
        bus.sdram_ok   = 1'b0;
        bus.sdram_data = 16'h0000;
        chk("cs_drop", {31'd0, bus.sdram_cs}, 32'd0);
    endtask

    // Download pulse over an outstanding demand with the ack landing inside it
    task automatic dwnld_test(input logic [15:0] a, input logic [7:0] exp_byte);
        logic [14:0] w;
        w = a[15:1];
        bus.pcm_addr = a;
        wait_cs("dl_req");
        chk("dl_addr", {17'd0, bus.sdram_addr}, {17'd0, w});
        step();
        dwnld_busy     = 1'b1;
        bus.sdram_ok   = 1'b1;
        bus.sdram_data = 16'hAAAA;
        step();
        bus.sdram_ok   = 1'b0;
        chk("dl_cs", {31'd0, bus.sdram_cs}, 32'd0);
        chk("dl_ok", {31'd0, bus.pcm_ok}, 32'd0);
        step();
        chk("dl_cs2", {31'd0, bus.sdram_cs}, 32'd0);
        dwnld_busy = 1'b0;
        serve(w, 16'h7788, 2);
        chk("dl_refill_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("dl_refill_data", {24'd0, bus.pcm_data}, {24'd0, exp_byte});
    endtask

    initial begin
        bus.pcm_addr   = 16'h0000;
        bus.sdram_data = 16'h0000;
        bus.sdram_ok   = 1'b0;

        // Reset values
        step(); step();
        chk("rst_cs", {31'd0, bus.sdram_cs}, 32'd0);
        chk("rst_addr", {17'd0, bus.sdram_addr}, 32'd0);
        chk("rst_ok", {31'd0, bus.pcm_ok}, 32'd0);
        chk("rst_data", {24'd0, bus.pcm_data}, 32'd0);
        rst = 1'b0;

        // First miss at address 0, ack 5 cycles later
        serve(15'h0000, 16'hBEEF, 5);
        chk("w0_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("w0_lo", {24'd0, bus.pcm_data}, 32'h0EF);
        bus.pcm_addr = 16'h0001;
        #1;
        chk("w0_hi_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("w0_hi", {24'd0, bus.pcm_data}, 32'h0BE);

`ifdef JTSBASKT_PCM_PREFETCH_EN
        // Hit on word 0 prefetches word 1
        serve(15'h0001, 16'h1234, 2);
        // Demand word 8, prefetch of word 9 follows by itself
        bus.pcm_addr = 16'h0010;
        serve(15'h0008, 16'h0A0B, 1);
        chk("w8_data", {24'd0, bus.pcm_data}, 32'h00B);
        serve(15'h0009, 16'hC0DE, 2);
        bus.pcm_addr = 16'h0012;
        #1;
        chk("w9_same_cycle_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("w9_data", {24'd0, bus.pcm_data}, 32'h0DE);
        // Jump away while the word 0xA prefetch is outstanding
        wait_cs("pfA_cs");
        chk("pfA_addr", {17'd0, bus.sdram_addr}, 32'h000A);
        bus.pcm_addr = 16'h2000;
        #1;
        chk("jump_ok_low", {31'd0, bus.pcm_ok}, 32'd0);
        serve(15'h000A, 16'h5A5A, 2);
        chk("after_pf_miss", {31'd0, bus.pcm_ok}, 32'd0);
        wait_cs("dem1000_cs");
        chk("dem1000_ok_low", {31'd0, bus.pcm_ok}, 32'd0);
        serve(15'h1000, 16'h2211, 3);
        chk("w1000_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("w1000_data", {24'd0, bus.pcm_data}, 32'h011);
        serve(15'h1001, 16'h0000, 1);
        // Tag wrap: hit on 0x7FFF prefetches word 0
        bus.pcm_addr = 16'hFFFE;
        serve(15'h7FFF, 16'hFACE, 2);
        chk("w7fff_data", {24'd0, bus.pcm_data}, 32'h0CE);
        serve(15'h0000, 16'h9988, 1);
        chk("wrap_keep_ok", {31'd0, bus.pcm_ok}, 32'd1);
        dwnld_test(16'h4000, 8'h88);
`else
        // No further request while reading within the cached word
        step(); step(); step();
        chk("no_req_cs", {31'd0, bus.sdram_cs}, 32'd0);
        chk("no_req_cnt", req_cnt, 32'd1);
        // Alternate between words 0x100 and 0x200, then bring in 0x300
        req_base = req_cnt;
        bus.pcm_addr = 16'h0200;
        serve(15'h0100, 16'h1122, 2);
        chk("w100_data", {24'd0, bus.pcm_data}, 32'h022);
        bus.pcm_addr = 16'h0401;
        serve(15'h0200, 16'h3344, 3);
        chk("w200_data", {24'd0, bus.pcm_data}, 32'h033);
        bus.pcm_addr = 16'h0201;
        #1;
        chk("alt100_data", {24'd0, bus.pcm_data}, 32'h011);
        bus.pcm_addr = 16'h0400;
        #1;
        chk("alt200_data", {24'd0, bus.pcm_data}, 32'h044);
        step();
        bus.pcm_addr = 16'h0600;
        serve(15'h0300, 16'h5566, 1);
        chk("w300_data", {24'd0, bus.pcm_data}, 32'h066);
        bus.pcm_addr = 16'h0400;
        #1;
        chk("keep200_ok", {31'd0, bus.pcm_ok}, 32'd1);
        chk("keep200_data", {24'd0, bus.pcm_data}, 32'h044);
        // Stray ack with no request outstanding
        bus.pcm_addr   = 16'h0601;
        bus.sdram_data = 16'hDEAD;
        bus.sdram_ok   = 1'b1;
        step();
        bus.sdram_ok   = 1'b0;
        chk("stray_data", {24'd0, bus.pcm_data}, 32'h055);
        chk("stray_cs", {31'd0, bus.sdram_cs}, 32'd0);
        chk("three_reqs", req_cnt - req_base, 32'd3);
        bus.pcm_addr = 16'h0200;
        #1;
        chk("evict100", {31'd0, bus.pcm_ok}, 32'd0);
        dwnld_test(16'h0200, 8'h88);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
